mem_port_arbiter: RTL and testbench

- Shares one backing memory port between two requesters: the icache refill port (read-only) and the processor data port (read/write).
- Sits between icache_1wa/processor data path and a single unified memory model. This replaces the split imem/dmem arrangement.
- Round-robin arbitration on contention. The grant is locked for the duration of a transaction.
- Memory-side request signals are registered. Read data and ready pass back to the winner combinationally.

---
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one registered memory port between the icache refill
// port and the data port. Define ARB_PERF_CNT_EN to add grant/conflict counters.
module mem_port_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    i_valid,
   output logic                    i_ready,
   input  logic [ADDR_WIDTH-1:0]   i_addr,
   output logic [DATA_WIDTH-1:0]   i_rdata,
   input  logic                    d_valid,
   output logic                    d_ready,
   input  logic [ADDR_WIDTH-1:0]   d_addr,
   input  logic [DATA_WIDTH-1:0]   d_wdata,
   input  logic [DATA_WIDTH/8-1:0] d_wstrb,
   output logic [DATA_WIDTH-1:0]   d_rdata,
   output logic                    mem_valid,
   output logic                    mem_instr,
   input  logic                    mem_ready,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   output logic [DATA_WIDTH/8-1:0] mem_wstrb,
   input  logic [DATA_WIDTH-1:0]   mem_rdata,
   output logic                    timeout_err,
`ifdef ARB_PERF_CNT_EN
   output logic [31:0]             perf_i_grants,
   output logic [31:0]             perf_d_grants,
   output logic [31:0]             perf_conflicts,
`endif
   output logic [1:0]              o_state
);

   localparam int STRB_W = DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_I = 2'd1,
      GNT_D = 2'd2
   } state_t;

   state_t                r_state;
   logic                  r_last_i;
   logic                  r_mem_valid;
   logic                  r_mem_instr;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [DATA_WIDTH-1:0] r_mem_wdata;
   logic [STRB_W-1:0]     r_mem_wstrb;
   logic [31:0]           r_wait_cnt;
   logic                  r_timeout_err;

   logic                  w_pick_i;
   logic                  w_pick_d;
   logic                  w_gnt_i;
   logic                  w_gnt_d;
   logic [31:0]           w_cnt_next;

   // Handshake: a requester holds valid with stable payload until its ready pulse;
   // ready is a 1-cycle pulse driven combinationally from mem_ready while granted.
   assign w_pick_i   = i_valid && (!d_valid || !r_last_i);
   assign w_pick_d   = d_valid && (!i_valid ||  r_last_i);
   assign w_gnt_i    = (r_state == GNT_I);
   assign w_gnt_d    = (r_state == GNT_D);
   assign w_cnt_next = (r_wait_cnt == 32'hFFFF_FFFF) ? r_wait_cnt : r_wait_cnt + 32'd1;

   assign i_ready     = w_gnt_i && mem_ready;
   assign d_ready     = w_gnt_d && mem_ready;
   assign i_rdata     = i_ready ? mem_rdata : '0;
   assign d_rdata     = d_ready ? mem_rdata : '0;
   assign mem_valid   = r_mem_valid;
   assign mem_instr   = r_mem_instr;
   assign mem_addr    = r_mem_addr;
   assign mem_wdata   = r_mem_wdata;
   assign mem_wstrb   = r_mem_wstrb;
   assign timeout_err = r_timeout_err;
   assign o_state     = r_state;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= IDLE;
         r_last_i      <= 1'b0;
         r_mem_valid   <= 1'b0;
         r_mem_instr   <= 1'b0;
         r_mem_addr    <= '0;
         r_mem_wdata   <= '0;
         r_mem_wstrb   <= '0;
         r_wait_cnt    <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_pick_i) begin
                  r_state     <= GNT_I;
                  r_last_i    <= 1'b1;
                  r_mem_valid <= 1'b1;
                  r_mem_instr <= 1'b1;
                  r_mem_addr  <= i_addr;
                  r_mem_wdata <= '0;
                  r_mem_wstrb <= '0;
                  r_wait_cnt  <= '0;
               end else if (w_pick_d) begin
                  r_state     <= GNT_D;
                  r_last_i    <= 1'b0;
                  r_mem_valid <= 1'b1;
                  r_mem_instr <= 1'b0;
                  r_mem_addr  <= d_addr;
                  r_mem_wdata <= d_wdata;
                  r_mem_wstrb <= d_wstrb;
                  r_wait_cnt  <= '0;
               end
            end
            GNT_I, GNT_D: begin
               if (mem_ready) begin
                  r_state     <= IDLE;
                  r_mem_valid <= 1'b0;
               end else begin
                  // A stalled grant is never aborted; the flag only reports it.
                  r_wait_cnt <= w_cnt_next;
                  if ((TIMEOUT_CYCLES != 0) && (w_cnt_next >= 32'(TIMEOUT_CYCLES)))
                     r_timeout_err <= 1'b1;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_mem_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef ARB_PERF_CNT_EN
   logic [31:0] r_perf_i;
   logic [31:0] r_perf_d;
   logic [31:0] r_perf_conf;
   logic        w_conflict;

   assign w_conflict = ((r_state == IDLE) && i_valid && d_valid) ||
                       (w_gnt_i && d_valid) || (w_gnt_d && i_valid);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_perf_i    <= '0;
         r_perf_d    <= '0;
         r_perf_conf <= '0;
      end else begin
         if ((r_state == IDLE) && w_pick_i)
            r_perf_i <= r_perf_i + 32'd1;
         if ((r_state == IDLE) && w_pick_d)
            r_perf_d <= r_perf_d + 32'd1;
         if (w_conflict)
            r_perf_conf <= r_perf_conf + 32'd1;
      end
   end

   assign perf_i_grants  = r_perf_i;
   assign perf_d_grants  = r_perf_d;
   assign perf_conflicts = r_perf_conf;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: task-driven scenarios with a memory
// responder task and an expected-response queue of {is_icache, rdata}.
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          i_valid;
   logic          i_ready;
   logic [AW-1:0] i_addr;
   logic [DW-1:0] i_rdata;
   logic          d_valid;
   logic          d_ready;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [SW-1:0] d_wstrb;
   logic [DW-1:0] d_rdata;
   logic          mem_valid;
   logic          mem_instr;
   logic          mem_ready;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [SW-1:0] mem_wstrb;
   logic [DW-1:0] mem_rdata;
   logic          timeout_err;
   logic [1:0]    o_state;
`ifdef ARB_PERF_CNT_EN
   logic [31:0]   perf_i_grants;
   logic [31:0]   perf_d_grants;
   logic [31:0]   perf_conflicts;
`endif

   int            checks = 0;
   int            failures = 0;
   int            cyc = 0;
   logic [32:0]   exp_q[$];

   mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .reset(reset),
      .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr), .i_rdata(i_rdata),
      .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_wstrb(d_wstrb), .d_rdata(d_rdata),
      .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_rdata(mem_rdata), .timeout_err(timeout_err),
`ifdef ARB_PERF_CNT_EN
      .perf_i_grants(perf_i_grants), .perf_d_grants(perf_d_grants),
      .perf_conflicts(perf_conflicts),
`endif
      .o_state(o_state)
   );

   // Clock and cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1);
   end

   task automatic apply_reset();
      reset = 1'b1;
      i_valid = 1'b0; i_addr = '0;
      d_valid = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
      mem_ready = 1'b0; mem_rdata = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // Memory responder: called on a negedge after a request is driven. Waits for the
   // grant, holds mem_ready low for lat-1 cycles, returns rdata, then drops the winner.
   task automatic serve(input int lat, input logic [DW-1:0] rdata,
                        output int wait_cyc, output bit timed_out,
                        output logic o_instr, output logic [AW-1:0] o_addr,
                        output logic [DW-1:0] o_wdata, output logic [SW-1:0] o_wstrb,
                        output logic o_iready, output logic o_dready,
                        output logic [DW-1:0] o_irdata, output logic [DW-1:0] o_drdata,
                        output int t_grant, output int t_ready);
      wait_cyc = 0; timed_out = 1'b0;
      o_instr = 1'b0; o_addr = '0; o_wdata = '0; o_wstrb = '0;
      o_iready = 1'b0; o_dready = 1'b0; o_irdata = '0; o_drdata = '0;
      t_grant = 0; t_ready = 0;
      do begin
         @(negedge clk);
         wait_cyc++;
      end while (!mem_valid && wait_cyc < 50);
      if (!mem_valid) begin
         timed_out = 1'b1;
         i_valid = 1'b0; d_valid = 1'b0;
         return;
      end
      t_grant = cyc;
      o_instr = mem_instr; o_addr = mem_addr; o_wdata = mem_wdata; o_wstrb = mem_wstrb;
      repeat (lat - 1) @(negedge clk);
      mem_ready = 1'b1; mem_rdata = rdata;
      #1;
      t_ready = cyc;
      o_iready = i_ready; o_dready = d_ready; o_irdata = i_rdata; o_drdata = d_rdata;
      @(negedge clk);
      mem_ready = 1'b0; mem_rdata = '0;
      if (o_instr) i_valid = 1'b0;
      else d_valid = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL reset_mem_valid got=%0h exp=0", mem_valid); end
      checks++; if (mem_instr !== 1'b0) begin failures++; $display("FAIL reset_mem_instr got=%0h exp=0", mem_instr); end
      checks++; if (mem_addr !== '0) begin failures++; $display("FAIL reset_mem_addr got=%0h exp=0", mem_addr); end
      checks++; if (mem_wdata !== '0) begin failures++; $display("FAIL reset_mem_wdata got=%0h exp=0", mem_wdata); end
      checks++; if (mem_wstrb !== '0) begin failures++; $display("FAIL reset_mem_wstrb got=%0h exp=0", mem_wstrb); end
      checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_timeout_err got=%0h exp=0", timeout_err); end
      checks++; if (o_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", o_state); end
      // mem_ready while idle must not produce any ready pulse
      mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      #1;
      checks++; if ({i_ready, d_ready} !== 2'b00) begin failures++; $display("FAIL idle_ready got=%b exp=00", {i_ready, d_ready}); end
      checks++; if ((i_rdata | d_rdata) !== '0) begin failures++; $display("FAIL idle_rdata got=%0h/%0h exp=0", i_rdata, d_rdata); end
      @(negedge clk);
      mem_ready = 1'b0; mem_rdata = '0;
      checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL idle_no_grant got=%0h exp=0", mem_valid); end
   endtask

   task automatic test_icache_read();
      int w, tg, tr; bit to; logic ins, ir, dr;
      logic [AW-1:0] a; logic [DW-1:0] wd, ird, drd; logic [SW-1:0] ws; logic [32:0] exp;
      i_valid = 1'b1; i_addr = 32'h100;
      exp_q.push_back({1'b1, 32'h0000_0013});
      serve(3, 32'h0000_0013, w, to, ins, a, wd, ws, ir, dr, ird, drd, tg, tr);
      checks++; if (to !== 1'b0) begin failures++; $display("FAIL icache_grant_timeout got=%0d exp=0", to); end
      checks++; if (w != 1) begin failures++; $display("FAIL icache_latency got=%0d exp=1", w); end
      checks++; if (ins !== 1'b1) begin failures++; $display("FAIL icache_mem_instr got=%0h exp=1", ins); end
      checks++; if (a !== 32'h100) begin failures++; $display("FAIL icache_mem_addr got=%0h exp=100", a); end
      checks++; if (ws !== '0) begin failures++; $display("FAIL icache_mem_wstrb got=%0h exp=0", ws); end
      checks++; if ({ir, dr} !== 2'b10) begin failures++; $display("FAIL icache_ready got=%b exp=10", {ir, dr}); end
      checks++; if (drd !== '0) begin failures++; $display("FAIL icache_d_rdata got=%0h exp=0", drd); end
      exp = exp_q.pop_front();
      checks++; if ({ins, (ins ? ird : drd)} !== exp) begin failures++; $display("FAIL icache_sb got=%0h exp=%0h", {ins, (ins ? ird : drd)}, exp); end
      checks++; if ({mem_valid, i_ready} !== 2'b00) begin failures++; $display("FAIL icache_after got=%b exp=00", {mem_valid, i_ready}); end
   endtask

   task automatic test_data_write();
      int w, tg, tr; bit to; logic ins, ir, dr;
      logic [AW-1:0] a; logic [DW-1:0] wd, ird, drd; logic [SW-1:0] ws; logic [32:0] exp;
      d_valid = 1'b1; d_addr = 32'h2000; d_wdata = 32'hCAFE_BABE; d_wstrb = 4'b0011;
      exp_q.push_back({1'b0, 32'h0000_0777});
      serve(2, 32'h0000_0777, w, to, ins, a, wd, ws, ir, dr, ird, drd, tg, tr);
      checks++; if (to !== 1'b0) begin failures++; $display("FAIL dwrite_grant_timeout got=%0d exp=0", to); end
      checks++; if ({ins, a, wd, ws} !== {1'b0, 32'h2000, 32'hCAFE_BABE, 4'b0011}) begin
         failures++; $display("FAIL dwrite_mem_fields got=%0h/%0h/%0h/%0h exp=0/2000/cafebabe/3", ins, a, wd, ws); end
      checks++; if ({ir, dr} !== 2'b01) begin failures++; $display("FAIL dwrite_ready got=%b exp=01", {ir, dr}); end
      checks++; if (ird !== '0) begin failures++; $display("FAIL dwrite_i_rdata got=%0h exp=0", ird); end
      exp = exp_q.pop_front();
      checks++; if ({ins, (ins ? ird : drd)} !== exp) begin failures++; $display("FAIL dwrite_sb got=%0h exp=%0h", {ins, (ins ? ird : drd)}, exp); end
      checks++; if (d_ready !== 1'b0) begin failures++; $display("FAIL dwrite_pulse got=%0h exp=0", d_ready); end
   endtask

   // Tie after reset goes to icache; requesters re-request at once, so grants alternate.
   task automatic test_tie_round_robin();
      int w, tg, tr; bit to; logic ins, ir, dr;
      logic [AW-1:0] a; logic [DW-1:0] wd, ird, drd; logic [SW-1:0] ws; logic [32:0] exp;
      apply_reset();
      i_valid = 1'b1; i_addr = 32'h40;
      d_valid = 1'b1; d_addr = 32'h80; d_wdata = 32'h1122_3344; d_wstrb = 4'hF;
      for (int k = 0; k < 4; k++) exp_q.push_back({((k % 2) == 0), 32'hA0 + 32'(k)});
      for (int k = 0; k < 4; k++) begin
         serve(2, 32'hA0 + 32'(k), w, to, ins, a, wd, ws, ir, dr, ird, drd, tg, tr);
         exp = exp_q.pop_front();
         checks++; if ({ins, (ins ? ird : drd)} !== exp) begin failures++; $display("FAIL tie_sb_%0d got=%0h exp=%0h", k, {ins, (ins ? ird : drd)}, exp); end
         if (k == 2) begin
            checks++; if ({wd, ws} !== '0) begin failures++; $display("FAIL tie_icache_wfields got=%0h/%0h exp=0/0", wd, ws); end
         end
         if (!i_valid) i_valid = 1'b1;
         if (!d_valid) d_valid = 1'b1;
      end
      i_valid = 1'b0; d_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int w, tg, tr, t0, tr_i, tg_d; bit to; logic ins, ir, dr;
      logic [AW-1:0] a; logic [DW-1:0] wd, ird, drd; logic [SW-1:0] ws; logic [32:0] exp;
      i_valid = 1'b1; i_addr = 32'h500;
      d_valid = 1'b1; d_addr = 32'h600; d_wdata = 32'h0; d_wstrb = 4'h0;
      t0 = cyc;
      exp_q.push_back({1'b1, 32'h5A});
      exp_q.push_back({1'b0, 32'h6B});
      serve(5, 32'h5A, w, to, ins, a, wd, ws, ir, dr, ird, drd, tg, tr);
      tr_i = tr;
      exp = exp_q.pop_front();
      checks++; if ({ins, (ins ? ird : drd)} !== exp) begin failures++; $display("FAIL b2b_first_sb got=%0h exp=%0h", {ins, (ins ? ird : drd)}, exp); end
      serve(1, 32'h6B, w, to, ins, a, wd, ws, ir, dr, ird, drd, tg, tr);
      tg_d = tg;
      exp = exp_q.pop_front();
      checks++; if ({ins, (ins ? ird : drd)} !== exp) begin failures++; $display("FAIL b2b_second_sb got=%0h exp=%0h", {ins, (ins ? ird : drd)}, exp); end
      checks++; if (tg_d - tr_i != 2) begin failures++; $display("FAIL b2b_first_idle got=%0d exp=2", tg_d - tr_i); end
      checks++; if (tg_d - t0 > 7) begin failures++; $display("FAIL b2b_d_wait got=%0d exp<=7", tg_d - t0); end
   endtask

   task automatic test_timeout();
      i_valid = 1'b1; i_addr = 32'h900;
      @(negedge clk);
      checks++; if ({mem_valid, timeout_err} !== 2'b10) begin failures++; $display("FAIL to_grant got=%b exp=10", {mem_valid, timeout_err}); end
      repeat (7) @(negedge clk);
      checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL to_early got=%0h exp=0", timeout_err); end
      @(negedge clk);
      checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL to_set got=%0h exp=1", timeout_err); end
      mem_ready = 1'b1; mem_rdata = 32'h0BAD_F00D;
      #1;
      checks++; if ({i_ready, i_rdata} !== {1'b1, 32'h0BAD_F00D}) begin failures++; $display("FAIL to_complete got=%0h/%0h exp=1/badf00d", i_ready, i_rdata); end
      @(negedge clk);
      mem_ready = 1'b0; mem_rdata = '0; i_valid = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL to_sticky got=%0h exp=1", timeout_err); end
      apply_reset();
      checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL to_cleared got=%0h exp=0", timeout_err); end
   endtask

   task automatic test_reset_mid_grant();
      d_valid = 1'b1; d_addr = 32'h3000; d_wdata = '0; d_wstrb = '0;
      @(negedge clk);
      checks++; if ({mem_valid, o_state} !== {1'b1, 2'd2}) begin failures++; $display("FAIL rmg_granted got=%0h/%0d exp=1/2", mem_valid, o_state); end
      reset = 1'b1;
      @(negedge clk);
      checks++; if ({mem_valid, o_state} !== {1'b0, 2'd0}) begin failures++; $display("FAIL rmg_reset got=%0h/%0d exp=0/0", mem_valid, o_state); end
      reset = 1'b0; d_valid = 1'b0;
      mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
      #1;
      checks++; if ({d_ready, d_rdata} !== {1'b0, 32'h0}) begin failures++; $display("FAIL rmg_no_ready got=%0h/%0h exp=0/0", d_ready, d_rdata); end
      @(negedge clk);
      mem_ready = 1'b0; mem_rdata = '0;
      checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL rmg_idle got=%0h exp=0", mem_valid); end
   endtask

   initial begin
      test_reset();
      test_icache_read();
      test_data_write();
      test_tie_round_robin();
      test_back_to_back();
      test_timeout();
      test_reset_mid_grant();
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
